sprite_mover_param: RTL and testbench
=====================================

SPRITE_MOVER_PARAM -- requirements
Module: sprite_mover_param

Interface
REQ-001 Parameter X_W, 9, width of X coordinate.
REQ-002 Parameter Y_W, 8, width of Y coordinate.
REQ-003 Parameter SCREEN_W, 320; SCREEN_H, 240: visible area in pixels.
REQ-004 Parameter START_X, 95; START_Y, 221: position after reset.
REQ-005 Parameter STEP, 1: pixels moved per axis per accepted move.
REQ-006 Parameter TICK_DIV, 6250000: clock cycles per move tick (8 Hz at 50 MHz).
REQ-007 Parameter QRY_TIMEOUT, 15: max cycles to wait for a walk-map response.
REQ-008 clock  in  1  single clock, all logic on posedge.
REQ-009 resetn  in  1  synchronous, active-low reset.
REQ-010 move  in  1  level request to step in direction dir.
REQ-011 dir  in  2  bit0: 0 = X+STEP, 1 = X-STEP; bit1: 0 = Y+STEP, 1 = Y-STEP.
REQ-012 lift_req  in  1  pulse requesting a vertical shift by lift_dy (platform moved).
REQ-013 lift_dy  in  Y_W  pixels to subtract from Y on lift.
REQ-014 qry_valid  out  1  walk-map query strobe; qry_x out X_W, qry_y out Y_W: candidate position.
REQ-015 rsp_valid  in  1  walk-map response strobe; rsp_ok in 1: candidate walkable.
REQ-016 rsp_tele  in  1  teleport hit; rsp_tx in X_W, rsp_ty in Y_W: teleport destination.
REQ-017 drawBG  out  1  erase request to sprite drawer; doneBG in 1: erase complete.
REQ-018 drawChar  out  1  draw request to sprite drawer; doneChar in 1: draw complete.
REQ-019 xCoordinate  out  X_W; yCoordinate  out  Y_W: current sprite position.
REQ-020 busy  out  1  high whenever state is not IDLE.

Function
REQ-021 States: IDLE, QUERY, WAIT_RSP, ERASE, WAIT_BG, UPDATE, DRAW, WAIT_CHAR.
REQ-022 Tick counter counts 0..TICK_DIV-1, wraps; tick = 1 for one cycle when counter = TICK_DIV-1; counter runs in all states.
REQ-023 IDLE: lift_req has priority: latch target (X, Y-lift_dy saturated at 0), go ERASE; else move & tick: compute candidate, go QUERY; else stay.
REQ-024 lift_req outside IDLE is held pending (1-bit flag) and serviced on next IDLE cycle; further lift_req while pending are dropped.
REQ-025 Candidate arithmetic at width X_W+1 / Y_W+1; out-of-bounds if candidate X = 0, Y = 0, X >= SCREEN_W, Y >= SCREEN_H, or underflow; out-of-bounds returns to IDLE without query.
REQ-026 QUERY: qry_valid = 1 for exactly one cycle with qry_x/qry_y = candidate; then WAIT_RSP.
REQ-027 WAIT_RSP: on rsp_valid: rsp_tele -> target = (rsp_tx, rsp_ty), go ERASE; else rsp_ok -> target = candidate, go ERASE; else IDLE.
REQ-028 WAIT_RSP: no rsp_valid within QRY_TIMEOUT cycles -> IDLE, position unchanged; late responses ignored in IDLE.
REQ-029 ERASE: drawBG = 1, one cycle; WAIT_BG: drawBG = 1 until doneBG, then UPDATE.
REQ-030 UPDATE: one cycle; xCoordinate/yCoordinate <= target.
REQ-031 DRAW: drawChar = 1, one cycle; WAIT_CHAR: drawChar = 1 until doneChar, then IDLE.
REQ-032 drawBG and drawChar never high together; coordinates change only in UPDATE.
REQ-033 Erase uses pre-update coordinates; draw uses post-update coordinates.
REQ-034 Held move yields at most one step per tick; move with tick not in IDLE is ignored.
REQ-035 No state waits on a done signal other than WAIT_BG/WAIT_CHAR; doneBG/doneChar in other states ignored.

Reset
REQ-036 resetn = 0 at posedge: state IDLE, xCoordinate = START_X, yCoordinate = START_Y, tick counter 0, lift pending 0, all strobes and draw outputs 0, busy 0.
REQ-037 Reset mid-operation (any state) aborts immediately to REQ-036 values; no further drawBG/drawChar issued.

Verification
REQ-038 Reset, TICK_DIV=4, move=1, dir=00, rsp ok after 2 cycles, doneBG/doneChar after 3 -> qry (96,222), drawBG, position (96,222), drawChar, IDLE.
REQ-039 Position (1,221), dir=01 (X-1) -> candidate X=0 out of bounds, no qry_valid, no drawBG, position unchanged.
REQ-040 Query answered rsp_tele=1, rsp_tx=126, rsp_ty=68 -> position becomes (126,68) after erase/draw.
REQ-041 No response for QRY_TIMEOUT cycles, then late rsp_valid -> IDLE, position unchanged, no drawBG.
REQ-042 lift_req with lift_dy=74 during WAIT_CHAR at Y=221 -> after return to IDLE, erase/draw cycle, Y=147; second lift_req while pending dropped; lift_dy=250 at Y=221 -> Y=0.
REQ-043 resetn asserted during WAIT_BG -> next cycle position (95,221), drawBG=0, busy=0.

Source files
------------

// File: rtl/sprite_mover_param.sv
// Sprite position controller: tick-paced moves checked against a walk map,
// platform lifts, and erase/redraw handshakes with the sprite drawer.
module sprite_mover_param #(
  parameter int unsigned X_W         = 9,
  parameter int unsigned Y_W         = 8,
  parameter int unsigned SCREEN_W    = 320,
  parameter int unsigned SCREEN_H    = 240,
  parameter int unsigned START_X     = 95,
  parameter int unsigned START_Y     = 221,
  parameter int unsigned STEP        = 1,
  parameter int unsigned TICK_DIV    = 6250000,
  parameter int unsigned QRY_TIMEOUT = 15
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           move,
  input  logic [1:0]     dir,
  input  logic           lift_req,
  input  logic [Y_W-1:0] lift_dy,
  output logic           qry_valid,
  output logic [X_W-1:0] qry_x,
  output logic [Y_W-1:0] qry_y,
  input  logic           rsp_valid,
  input  logic           rsp_ok,
  input  logic           rsp_tele,
  input  logic [X_W-1:0] rsp_tx,
  input  logic [Y_W-1:0] rsp_ty,
  output logic           drawBG,
  input  logic           doneBG,
  output logic           drawChar,
  input  logic           doneChar,
  output logic [X_W-1:0] xCoordinate,
  output logic [Y_W-1:0] yCoordinate,
  output logic           busy
);

  localparam int unsigned XC_W   = X_W + 1;
  localparam int unsigned YC_W   = Y_W + 1;
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TO_W   = (QRY_TIMEOUT > 1) ? $clog2(QRY_TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_QUERY     = 3'd1;
  localparam logic [2:0] S_WAIT_RSP  = 3'd2;
  localparam logic [2:0] S_ERASE     = 3'd3;
  localparam logic [2:0] S_WAIT_BG   = 3'd4;
  localparam logic [2:0] S_UPDATE    = 3'd5;
  localparam logic [2:0] S_DRAW      = 3'd6;
  localparam logic [2:0] S_WAIT_CHAR = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              pend_q, pend_d;
  logic [Y_W-1:0]    pend_dy_q, pend_dy_d;
  logic [X_W-1:0]    cand_x_q, cand_x_d;
  logic [Y_W-1:0]    cand_y_q, cand_y_d;
  logic [X_W-1:0]    tgt_x_q, tgt_x_d;
  logic [Y_W-1:0]    tgt_y_q, tgt_y_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              qry_valid_q, qry_valid_d;
  logic              draw_bg_q, draw_bg_d;
  logic              draw_char_q, draw_char_d;
  logic              busy_q, busy_d;

  logic              tick_c;
  logic [XC_W-1:0]   cx_c;
  logic [YC_W-1:0]   cy_c;
  logic              cand_oob_c;
  logic              lift_go_c;
  logic [Y_W-1:0]    eff_dy_c;
  logic [Y_W-1:0]    lift_y_c;

  assign tick_c = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

  // Candidate is formed one bit wider so underflow and overshoot stay visible
  always_comb begin
    cx_c = dir[0] ? ({1'b0, x_q} - XC_W'(STEP)) : ({1'b0, x_q} + XC_W'(STEP));
    cy_c = dir[1] ? ({1'b0, y_q} - YC_W'(STEP)) : ({1'b0, y_q} + YC_W'(STEP));
    cand_oob_c = (dir[0] && ({1'b0, x_q} < XC_W'(STEP))) ||
                 (dir[1] && ({1'b0, y_q} < YC_W'(STEP))) ||
                 (cx_c == '0) || (cy_c == '0) ||
                 (cx_c >= XC_W'(SCREEN_W)) || (cy_c >= YC_W'(SCREEN_H));
  end

  // A pending lift uses the shift amount captured when it was first requested
  always_comb begin
    lift_go_c = pend_q || lift_req;
    eff_dy_c  = pend_q ? pend_dy_q : lift_dy;
    lift_y_c  = (eff_dy_c > y_q) ? '0 : (y_q - eff_dy_c);
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_c ? '0 : (tick_cnt_q + TICK_W'(1));
    wait_cnt_d  = wait_cnt_q;
    pend_d      = pend_q;
    pend_dy_d   = pend_dy_q;
    cand_x_d    = cand_x_q;
    cand_y_d    = cand_y_q;
    tgt_x_d     = tgt_x_q;
    tgt_y_d     = tgt_y_q;
    x_d         = x_q;
    y_d         = y_q;

    if (state_q == S_IDLE) begin
      pend_d = 1'b0;
    end else if (lift_req && !pend_q) begin
      pend_d    = 1'b1;
      pend_dy_d = lift_dy;
    end

    case (state_q)
      S_IDLE: begin
        if (lift_go_c) begin
          tgt_x_d = x_q;
          tgt_y_d = lift_y_c;
          state_d = S_ERASE;
        end else if (move && tick_c && !cand_oob_c) begin
          cand_x_d = cx_c[X_W-1:0];
          cand_y_d = cy_c[Y_W-1:0];
          state_d  = S_QUERY;
        end
      end
      S_QUERY: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (rsp_valid) begin
          if (rsp_tele) begin
            tgt_x_d = rsp_tx;
            tgt_y_d = rsp_ty;
            state_d = S_ERASE;
          end else if (rsp_ok) begin
            tgt_x_d = cand_x_q;
            tgt_y_d = cand_y_q;
            state_d = S_ERASE;
          end else begin
            state_d = S_IDLE;
          end
        end else if (wait_cnt_q == TO_W'(QRY_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      S_ERASE:     state_d = S_WAIT_BG;
      S_WAIT_BG:   if (doneBG) state_d = S_UPDATE;
      S_UPDATE: begin
        x_d     = tgt_x_q;
        y_d     = tgt_y_q;
        state_d = S_DRAW;
      end
      S_DRAW:      state_d = S_WAIT_CHAR;
      S_WAIT_CHAR: if (doneChar) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    qry_valid_d = (state_d == S_QUERY);
    draw_bg_d   = (state_d == S_ERASE) || (state_d == S_WAIT_BG);
    draw_char_d = (state_d == S_DRAW) || (state_d == S_WAIT_CHAR);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      pend_q      <= 1'b0;
      pend_dy_q   <= '0;
      cand_x_q    <= '0;
      cand_y_q    <= '0;
      tgt_x_q     <= '0;
      tgt_y_q     <= '0;
      x_q         <= X_W'(START_X);
      y_q         <= Y_W'(START_Y);
      qry_valid_q <= 1'b0;
      draw_bg_q   <= 1'b0;
      draw_char_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      pend_q      <= pend_d;
      pend_dy_q   <= pend_dy_d;
      cand_x_q    <= cand_x_d;
      cand_y_q    <= cand_y_d;
      tgt_x_q     <= tgt_x_d;
      tgt_y_q     <= tgt_y_d;
      x_q         <= x_d;
      y_q         <= y_d;
      qry_valid_q <= qry_valid_d;
      draw_bg_q   <= draw_bg_d;
      draw_char_q <= draw_char_d;
      busy_q      <= busy_d;
    end
  end

  assign qry_valid   = qry_valid_q;
  assign qry_x       = cand_x_q;
  assign qry_y       = cand_y_q;
  assign drawBG      = draw_bg_q;
  assign drawChar    = draw_char_q;
  assign xCoordinate = x_q;
  assign yCoordinate = y_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sprite_mover_param.sv
// Bench for sprite_mover_param: transaction-level position model, a per-cycle
// monitor, directed scenarios and a randomized run of moves and lifts.
module tb_sprite_mover_param;

  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int SW  = 320;
  localparam int SH  = 240;
  localparam int SX  = 95;
  localparam int SY  = 221;
  localparam int STP = 1;
  localparam int TD  = 4;
  localparam int QT  = 15;

  logic           clock = 1'b0;
  logic           resetn;
  logic           move;
  logic [1:0]     dir;
  logic           lift_req;
  logic [Y_W-1:0] lift_dy;
  logic           qry_valid;
  logic [X_W-1:0] qry_x;
  logic [Y_W-1:0] qry_y;
  logic           rsp_valid, rsp_ok, rsp_tele;
  logic [X_W-1:0] rsp_tx;
  logic [Y_W-1:0] rsp_ty;
  logic           drawBG, doneBG, drawChar, doneChar;
  logic [X_W-1:0] xCoordinate;
  logic [Y_W-1:0] yCoordinate;
  logic           busy;

  sprite_mover_param #(
    .X_W(X_W), .Y_W(Y_W), .SCREEN_W(SW), .SCREEN_H(SH),
    .START_X(SX), .START_Y(SY), .STEP(STP), .TICK_DIV(TD), .QRY_TIMEOUT(QT)
  ) dut (
    .clock(clock), .resetn(resetn), .move(move), .dir(dir),
    .lift_req(lift_req), .lift_dy(lift_dy),
    .qry_valid(qry_valid), .qry_x(qry_x), .qry_y(qry_y),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_tele(rsp_tele),
    .rsp_tx(rsp_tx), .rsp_ty(rsp_ty),
    .drawBG(drawBG), .doneBG(doneBG), .drawChar(drawChar), .doneChar(doneChar),
    .xCoordinate(xCoordinate), .yCoordinate(yCoordinate), .busy(busy)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model state: committed position plus the erase/draw expectations
  int m_x, m_y, old_x, old_y, new_x, new_y;
  int exp_qx, exp_qy, last_qx, last_qy;
  int n_qry, n_bg;
  bit char_seen, chk_en, prev_bg;
  int ncyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat0(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  task automatic tick1();
    @(posedge clock);
    #1;
  endtask

  // Edges since the last reset edge; a tick is sampled on every TD-th one
  always @(posedge clock) ncyc <= resetn ? ncyc + 1 : 0;

  always @(negedge clock) begin
    if (chk_en) begin
      chk("draw_exclusive", int'(drawBG && drawChar), 0);
      if (qry_valid) begin
        n_qry++;
        last_qx = int'(qry_x);
        last_qy = int'(qry_y);
        chk("qry_x", int'(qry_x), exp_qx);
        chk("qry_y", int'(qry_y), exp_qy);
        chk("qry_on_tick", ncyc % TD, 0);
        chk("qry_busy", int'(busy), 1);
      end
      if (drawBG) begin
        if (!prev_bg) n_bg++;
        chk("bg_busy", int'(busy), 1);
      end
      prev_bg = drawBG;
      if (drawChar) begin
        char_seen = 1'b1;
        chk("x_at_draw", int'(xCoordinate), new_x);
        chk("y_at_draw", int'(yCoordinate), new_y);
      end else if (!char_seen) begin
        chk("x_hold", int'(xCoordinate), old_x);
        chk("y_hold", int'(yCoordinate), old_y);
      end
    end
  end

  // Drives the drawer handshakes for one erase/draw pass and commits the target
  task automatic serve(input int tx, input int ty, input int bg_d, input int ch_d,
                       input bit mid, input int mid_dy);
    int k;
    new_x = tx;
    new_y = ty;
    k = 0;
    while (!drawBG && k < 40) begin tick1(); k++; end
    if (!drawBG) begin chk("erase_start", 0, 1); return; end
    tick1();
    repeat (bg_d) tick1();
    doneBG = 1'b1;
    tick1();
    doneBG = 1'b0;
    k = 0;
    while (!drawChar && k < 10) begin tick1(); k++; end
    if (!drawChar) begin chk("draw_start", 0, 1); return; end
    tick1();
    if (mid) begin
      lift_req = 1'b1; lift_dy = Y_W'(mid_dy);
      tick1();
      lift_req = 1'b0;
      tick1();
      lift_req = 1'b1; lift_dy = Y_W'(5);
      tick1();
      lift_req = 1'b0;
    end
    repeat (ch_d) tick1();
    doneChar = 1'b1;
    tick1();
    doneChar = 1'b0;
    chk("busy_end", int'(busy), 0);
    chk("x_end", int'(xCoordinate), tx);
    chk("y_end", int'(yCoordinate), ty);
    m_x = tx; m_y = ty; old_x = tx; old_y = ty;
    char_seen = 1'b0;
  endtask

  // mode: 0 walkable, 1 blocked, 2 teleport to (tx,ty), 3 no answer in time
  task automatic move_op(input logic [1:0] d, input int mode, input int tx, input int ty,
                         input int rsp_d, input int bg_d, input int ch_d,
                         input bit mid, input int mid_dy);
    int cx, cy, rd;
    bit oob, got, saw_busy;
    cx = d[0] ? m_x - STP : m_x + STP;
    cy = d[1] ? m_y - STP : m_y + STP;
    oob = (cx <= 0) || (cy <= 0) || (cx >= SW) || (cy >= SH);
    exp_qx = cx; exp_qy = cy;
    n_qry = 0; n_bg = 0;
    dir = d; move = 1'b1;
    got = 1'b0; saw_busy = 1'b0;
    for (int i = 0; i < TD + 2; i++) begin
      tick1();
      if (busy) saw_busy = 1'b1;
      if (qry_valid) begin got = 1'b1; break; end
    end
    move = 1'b0;
    if (oob) begin
      repeat (2) tick1();
      chk("oob_qry", n_qry, 0);
      chk("oob_busy", int'(saw_busy | busy), 0);
      chk("oob_bg", n_bg, 0);
      return;
    end
    if (!got) begin chk("qry_seen", 0, 1); return; end
    rd = (mode == 3) ? QT + 2 : rsp_d;
    tick1();
    repeat (rd) tick1();
    rsp_valid = 1'b1;
    rsp_tele  = (mode == 2);
    rsp_ok    = (mode == 0) || (mode == 3) || ((mode == 2) && ($urandom_range(0, 1) == 1));
    rsp_tx    = X_W'(tx);
    rsp_ty    = Y_W'(ty);
    tick1();
    rsp_valid = 1'b0; rsp_ok = 1'b0; rsp_tele = 1'b0;
    if (mode == 1 || mode == 3) begin
      repeat (3) tick1();
      chk("noerase_busy", int'(busy), 0);
      chk("noerase_bg", n_bg, 0);
      chk("noerase_qry", n_qry, 1);
      return;
    end
    if (mode == 2) serve(tx, ty, bg_d, ch_d, mid, mid_dy);
    else           serve(cx, cy, bg_d, ch_d, mid, mid_dy);
    chk("qry_once", n_qry, 1);
    if (mid) serve(m_x, sat0(m_y - mid_dy), bg_d, ch_d, 1'b0, 0);
    repeat (3) tick1();
    chk("idle_after", int'(busy), 0);
  endtask

  task automatic lift_op(input int dy, input int bg_d, input int ch_d);
    n_qry = 0;
    lift_req = 1'b1; lift_dy = Y_W'(dy);
    tick1();
    lift_req = 1'b0;
    serve(m_x, sat0(m_y - dy), bg_d, ch_d, 1'b0, 0);
    chk("lift_noqry", n_qry, 0);
    repeat (2) tick1();
    chk("lift_idle", int'(busy), 0);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; move = 1'b0; dir = 2'b00; lift_req = 1'b0; lift_dy = '0;
    rsp_valid = 1'b0; rsp_ok = 1'b0; rsp_tele = 1'b0; rsp_tx = '0; rsp_ty = '0;
    doneBG = 1'b0; doneChar = 1'b0; chk_en = 1'b0;
    repeat (3) tick1();
    chk("rst_x", int'(xCoordinate), 95);
    chk("rst_y", int'(yCoordinate), 221);
    chk("rst_busy", int'(busy), 0);
    chk("rst_qry", int'(qry_valid), 0);
    chk("rst_bg", int'(drawBG), 0);
    chk("rst_char", int'(drawChar), 0);
    resetn = 1'b1;
    m_x = SX; m_y = SY; old_x = SX; old_y = SY; char_seen = 1'b0; prev_bg = 1'b0;
    chk_en = 1'b1;

    // Walkable step from the start position
    move_op(2'b00, 0, 0, 0, 1, 2, 2, 1'b0, 0);
    chk("first_qx", last_qx, 96);
    chk("first_qy", last_qy, 222);
    chk("first_x", int'(xCoordinate), 96);
    chk("first_y", int'(yCoordinate), 222);

    // Left edge: X-1 from X=1 is out of bounds
    move_op(2'b00, 2, 1, 221, 0, 0, 0, 1'b0, 0);
    move_op(2'b01, 0, 0, 0, 0, 0, 0, 1'b0, 0);
    chk("edge_x", int'(xCoordinate), 1);
    chk("edge_y", int'(yCoordinate), 221);

    move_op(2'b00, 2, 126, 68, 3, 1, 1, 1'b0, 0);
    chk("tele_x", int'(xCoordinate), 126);
    chk("tele_y", int'(yCoordinate), 68);

    move_op(2'b10, 3, 0, 0, 0, 0, 0, 1'b0, 0);
    chk("timeout_x", int'(xCoordinate), 126);
    chk("timeout_y", int'(yCoordinate), 68);

    move_op(2'b11, 1, 0, 0, 4, 0, 0, 1'b0, 0);

    // Lift arriving during the draw handshake is serviced afterwards
    move_op(2'b00, 2, 130, 221, 0, 1, 6, 1'b1, 74);
    chk("lift_x", int'(xCoordinate), 130);
    chk("lift_y", int'(yCoordinate), 147);
    move_op(2'b00, 2, 130, 221, 0, 0, 0, 1'b0, 0);
    lift_op(250, 1, 1);
    chk("lift_sat_y", int'(yCoordinate), 0);

    // Lift beats a move on the same tick
    for (int i = 0; i < TD && ((ncyc + 1) % TD) != 0; i++) tick1();
    n_qry = 0;
    dir = 2'b00; move = 1'b1; lift_req = 1'b1; lift_dy = Y_W'(3);
    tick1();
    move = 1'b0; lift_req = 1'b0;
    serve(m_x, 0, 0, 0, 1'b0, 0);
    chk("prio_noqry", n_qry, 0);

    // Reset while waiting for the erase to complete
    n_bg = 0;
    lift_req = 1'b1; lift_dy = Y_W'(1);
    tick1();
    lift_req = 1'b0;
    chk("pre_rst_bg", int'(drawBG), 1);
    tick1();
    chk_en = 1'b0;
    resetn = 1'b0;
    tick1();
    chk("midrst_x", int'(xCoordinate), 95);
    chk("midrst_y", int'(yCoordinate), 221);
    chk("midrst_bg", int'(drawBG), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_char", int'(drawChar), 0);
    resetn = 1'b1;
    m_x = SX; m_y = SY; old_x = SX; old_y = SY; char_seen = 1'b0; n_bg = 0;
    chk_en = 1'b1;
    doneBG = 1'b1;
    tick1();
    doneBG = 1'b0;
    repeat (6) tick1();
    chk("postrst_bg", n_bg, 0);
    chk("postrst_busy", int'(busy), 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        lift_op($urandom_range(0, 60), $urandom_range(0, 4), $urandom_range(0, 4));
      end else begin
        move_op(2'($urandom_range(0, 3)), $urandom_range(0, 3),
                $urandom_range(0, SW - 1), $urandom_range(0, SH - 1),
                $urandom_range(0, QT - 3), $urandom_range(0, 4), $urandom_range(0, 4),
                ($urandom_range(0, 4) == 0), $urandom_range(0, 100));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
